// File: rtl/dct_ctrl_pkg.sv
// Shared constants and FSM state encoding for the y_dct front-end sequencer.
package dct_ctrl_pkg;

  localparam int unsigned BLOCK_PIXELS       = 64;
  localparam int unsigned PTR_W              = $clog2(BLOCK_PIXELS);
  localparam int unsigned DEF_CLEAR_CYCLES   = 2;
  localparam int unsigned DEF_FLUSH_CYCLES   = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000;

  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_FILL     = 3'd0;
  localparam logic [ST_W-1:0] ST_CLEAR    = 3'd1;
  localparam logic [ST_W-1:0] ST_FEED     = 3'd2;
  localparam logic [ST_W-1:0] ST_FLUSH    = 3'd3;
  localparam logic [ST_W-1:0] ST_WAIT_OUT = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE     = 3'd5;
  localparam logic [ST_W-1:0] ST_ERR      = 3'd6;

endpackage

// File: rtl/dct_pix_buf.sv
// One-block pixel buffer: single write port, single registered read port.
module dct_pix_buf
  import dct_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [BLOCK_PIXELS];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  // Storage carries no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dct_block_sequencer.sv
// Buffers one 8x8 block, clears y_dct, replays the block as a gap-free
// enable burst plus flush, then waits for the core's output_enable.
module dct_block_sequencer
  import dct_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int unsigned FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              dct_clear,
  output logic              dct_enable,
  output logic [DATA_W-1:0] dct_data,
  input  logic              dct_output_enable,
  output logic              coef_valid,
  output logic              block_done,
  output logic              timeout_err,
  output logic              busy,
  output logic [CNT_W-1:0]  block_count
);

  localparam int unsigned SEQ_W =
    $clog2(TIMEOUT_CYCLES + BLOCK_PIXELS + CLEAR_CYCLES + FLUSH_CYCLES);

  logic [ST_W-1:0]  state_d, state_q;
  logic [SEQ_W-1:0] seq_d, seq_q;
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic             dct_clear_d, dct_clear_q;
  logic             dct_enable_d, dct_enable_q;
  logic             coef_valid_d, coef_valid_q;
  logic             block_done_d, block_done_q;
  logic             timeout_err_d, timeout_err_q;
  logic             busy_d, busy_q;
  logic [CNT_W-1:0] block_count_d, block_count_q;
  logic             wr_en;
  logic             rd_en;

  dct_pix_buf #(.DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (pix_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (dct_data)
  );

  assign pix_ready = (state_q == ST_FILL);

  // Next-state logic; seq_q is reused as the per-state cycle counter.
  always_comb begin
    state_d       = state_q;
    seq_d         = seq_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    block_count_d = block_count_q;
    timeout_err_d = timeout_err_q;
    wr_en         = 1'b0;
    rd_en         = 1'b0;

    case (state_q)
      ST_FILL: begin
        if (pix_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (wr_ptr_q == PTR_W'(BLOCK_PIXELS - 1)) begin
            state_d  = ST_CLEAR;
            seq_d    = '0;
            rd_ptr_d = '0;
          end
        end
      end
      ST_CLEAR: begin
        if (seq_q == SEQ_W'(CLEAR_CYCLES - 1)) begin
          // Prefetch pixel 0 so the first enable cycle already has data.
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          state_d  = ST_FEED;
          seq_d    = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      ST_FEED: begin
        if (seq_q == SEQ_W'(BLOCK_PIXELS - 1)) begin
          state_d = ST_FLUSH;
          seq_d   = '0;
        end else begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          seq_d    = seq_q + SEQ_W'(1);
        end
      end
      ST_FLUSH: begin
        if (seq_q == SEQ_W'(FLUSH_CYCLES - 1)) begin
          state_d = ST_WAIT_OUT;
          seq_d   = '0;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      ST_WAIT_OUT: begin
        if (dct_output_enable) begin
          state_d       = ST_DONE;
          block_count_d = block_count_q + CNT_W'(1);
        end else if (seq_q == SEQ_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = ST_ERR;
          timeout_err_d = 1'b1;
        end else begin
          seq_d = seq_q + SEQ_W'(1);
        end
      end
      ST_DONE, ST_ERR: begin
        wr_ptr_d = '0;
        state_d  = ST_FILL;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    // Outputs are registered from the upcoming state.
    dct_clear_d  = (state_d == ST_CLEAR) || (state_d == ST_ERR);
    dct_enable_d = (state_d == ST_FEED) || (state_d == ST_FLUSH);
    coef_valid_d = (state_d == ST_DONE);
    block_done_d = (state_d == ST_DONE);
    busy_d       = (state_d != ST_FILL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FILL;
      seq_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      dct_clear_q   <= 1'b0;
      dct_enable_q  <= 1'b0;
      coef_valid_q  <= 1'b0;
      block_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      seq_q         <= seq_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      dct_clear_q   <= dct_clear_d;
      dct_enable_q  <= dct_enable_d;
      coef_valid_q  <= coef_valid_d;
      block_done_q  <= block_done_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      block_count_q <= block_count_d;
    end
  end

  assign dct_clear   = dct_clear_q;
  assign dct_enable  = dct_enable_q;
  assign coef_valid  = coef_valid_q;
  assign block_done  = block_done_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;
  assign block_count = block_count_q;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// Bench for dct_block_sequencer: randomized blocks checked against a
// block-level timeline model (clear, burst, wait, done/err).
module tb_dct_block_sequencer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int CLR    = 2;
  localparam int FLU    = 2;
  localparam int TMO    = 1000;
  localparam int NPIX   = 64;
  localparam int WAIT_T = CLR + NPIX + FLU + 1;   // first WAIT_OUT cycle after last accept
  localparam int OE_LAT   = 0;
  localparam int OE_NEVER = 1;
  localparam int OE_STALE = 2;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              dct_clear;
  logic              dct_enable;
  logic [DATA_W-1:0] dct_data;
  logic              dct_output_enable;
  logic              coef_valid;
  logic              block_done;
  logic              timeout_err;
  logic              busy;
  logic [CNT_W-1:0]  block_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_m    = 0;
  bit err_m    = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  dct_block_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .pix_data          (pix_data),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .dct_clear         (dct_clear),
    .dct_enable        (dct_enable),
    .dct_data          (dct_data),
    .dct_output_enable (dct_output_enable),
    .coef_valid        (coef_valid),
    .block_done        (block_done),
    .timeout_err       (timeout_err),
    .busy              (busy),
    .block_count       (block_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] pix_pattern(input int mode, input int idx);
    logic [5:0] i;
    i = 6'(idx);
    case (mode)
      0:       return 8'd128;
      1:       return (i[0] ^ i[3]) ? 8'd255 : 8'd0;
      default: return 8'($urandom);
    endcase
  endfunction

  // Present pixels until 64 are accepted; gap>0 drops valid every gap-th cycle.
  task automatic fill_block(input int mode, input int gap, input bit stale);
    int n;
    int cyc;
    logic v;
    logic [DATA_W-1:0] d;
    n = 0;
    cyc = 0;
    exp_q.delete();
    while (n < NPIX) begin
      @(negedge clk);
      cyc++;
      check_eq("fill_ready", 64'(pix_ready), 64'(1));
      check_eq("fill_flags", 64'({dct_clear, dct_enable, coef_valid, block_done, busy}), 64'(0));
      check_eq("fill_count", 64'(block_count), 64'(cnt_m));
      check_eq("fill_err", 64'(timeout_err), 64'(err_m));
      if (cyc >= 2000) begin
        check_eq("fill_bound", 64'(n), 64'(NPIX));
        break;
      end
      v = (gap == 0) || ((cyc % gap) != 0);
      d = pix_pattern(mode, n);
      pix_valid = v;
      pix_data = d;
      dct_output_enable = stale;
      if (v && pix_ready) begin
        exp_q.push_back(d);
        n++;
      end
    end
  endtask

  // Cycle t=1 is the cycle after the 64th accept; ends on DONE/ERR or abort_at.
  task automatic run_block_out(input int oe_mode, input int lat, input int abort_at);
    int end_t;
    int idx;
    logic [4:0] exp_v;
    end_t = (oe_mode == OE_NEVER) ? WAIT_T + TMO : WAIT_T + lat + 1;
    for (int t = 1; t <= end_t; t++) begin
      @(negedge clk);
      if (t == end_t) begin
        if (oe_mode == OE_NEVER) err_m = 1'b1;
        else cnt_m = (cnt_m + 1) % 65536;
      end
      if (t <= CLR)          exp_v = 5'b10001;
      else if (t < WAIT_T)   exp_v = 5'b01001;
      else if (t < end_t)    exp_v = 5'b00001;
      else if (oe_mode == OE_NEVER) exp_v = 5'b10001;
      else                   exp_v = 5'b00111;
      check_eq("out_flags", 64'({dct_clear, dct_enable, coef_valid, block_done, busy}), 64'(exp_v));
      check_eq("ready_low", 64'(pix_ready), 64'(0));
      check_eq("block_count", 64'(block_count), 64'(cnt_m));
      check_eq("timeout_err", 64'(timeout_err), 64'(err_m));
      if (t > CLR && t < WAIT_T) begin
        idx = t - CLR - 1;
        if (idx > NPIX - 1) idx = NPIX - 1;
        check_eq("dct_data", 64'(dct_data), 64'(exp_q[idx]));
      end
      case (oe_mode)
        OE_LAT:   dct_output_enable = (t >= WAIT_T + lat) && (t < end_t);
        OE_NEVER: dct_output_enable = 1'b0;
        default:  dct_output_enable = (t < end_t);
      endcase
      pix_valid = 1'b1;
      pix_data = 8'($urandom);
      if (t == abort_at) break;
    end
  endtask

  initial begin
    rst = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    dct_output_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_flags", 64'({dct_clear, dct_enable, coef_valid, block_done, busy}), 64'(0));
    check_eq("rst_data", 64'(dct_data), 64'(0));
    check_eq("rst_count", 64'(block_count), 64'(0));
    check_eq("rst_err", 64'(timeout_err), 64'(0));
    rst = 1'b1;

    fill_block(0, 0, 1'b0);
    run_block_out(OE_LAT, int'($urandom_range(3, 40)), 0);
    fill_block(1, 3, 1'b0);
    run_block_out(OE_LAT, int'($urandom_range(3, 40)), 0);
    fill_block(2, 0, 1'b0);
    run_block_out(OE_NEVER, 0, 0);
    fill_block(2, 4, 1'b1);
    run_block_out(OE_STALE, 0, 0);

    // Asynchronous reset during enable cycle 30 of a block.
    fill_block(2, 0, 1'b0);
    run_block_out(OE_LAT, 10, CLR + 30);
    rst = 1'b0;
    pix_valid = 1'b0;
    dct_output_enable = 1'b0;
    #1;
    cnt_m = 0;
    err_m = 1'b0;
    check_eq("arst_flags", 64'({dct_clear, dct_enable, coef_valid, block_done, busy}), 64'(0));
    check_eq("arst_data", 64'(dct_data), 64'(0));
    check_eq("arst_count", 64'(block_count), 64'(0));
    check_eq("arst_err", 64'(timeout_err), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_eq("idle_ready", 64'(pix_ready), 64'(1));
      check_eq("idle_flags", 64'({dct_clear, dct_enable, coef_valid, block_done, busy}), 64'(0));
    end

    for (int b = 0; b < 3; b++) begin
      fill_block(2, int'($urandom_range(2, 5)), 1'b0);
      run_block_out(OE_LAT, int'($urandom_range(1, 30)), 0);
    end
    @(negedge clk);
    check_eq("final_count", 64'(block_count), 64'(3));
    check_eq("final_ready", 64'(pix_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_block_sequencer.md
Name: dct_block_sequencer

Overview:
Front-end controller for the y_dct 8x8 luma DCT core.
- Collects an incoming pixel stream (gaps allowed) into a 64-entry block buffer.
- Clears the core, then replays the block as a contiguous 64-cycle enable burst plus flush cycles.
- Waits for the core's output_enable and signals downstream when coefficients are valid.
- Sits between the colour-conversion stage and y_dct; one block is in flight at a time.

Parameters:
DATA_W, 8, pixel width
BLOCK_PIXELS, 64, pixels per block (8x8)
CLEAR_CYCLES, 2, cycles dct_clear is held before a block
FLUSH_CYCLES, 2, extra enable cycles after the last pixel
TIMEOUT_CYCLES, 1000, maximum wait for dct_output_enable
CNT_W, 16, width of block_count

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
pix_data  in  DATA_W  input pixel, raster order within the block
pix_valid  in  1  pix_data valid
pix_ready  out  1  sequencer can accept; transfer when valid&&ready
dct_clear  out  1  clear to y_dct (drives its reset via the top level)
dct_enable  out  1  y_dct enable
dct_data  out  DATA_W  y_dct data_in
dct_output_enable  in  1  y_dct output_enable
coef_valid  out  1  1-cycle pulse; Z*_final are valid this cycle
block_done  out  1  1-cycle pulse, coincident with coef_valid
timeout_err  out  1  sticky; set on timeout, cleared only by rst
busy  out  1  high in every state except FILL
block_count  out  CNT_W  completed blocks; wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=0, asynchronous): state=FILL, write/read pointers=0, all outputs 0, block_count=0, timeout_err=0. Buffer contents are don't-care. Reset mid-block abandons the block; no partial replay occurs after release.
- FILL: pix_ready=1. Each accepted pixel is written at wr_ptr, and wr_ptr increments. Input gaps are tolerated indefinitely. When the 64th pixel is accepted (cycle T), the next state is CLEAR and pix_ready is 0 from T+1.
- CLEAR: dct_clear=1 for exactly CLEAR_CYCLES cycles (T+1..T+CLEAR_CYCLES). The buffer read of address 0 is prefetched in the last CLEAR cycle.
- FEED: dct_enable=1 for 64 cycles starting at T+CLEAR_CYCLES+1. dct_data = buffer[k] in the k-th enable cycle, in the same order as written. There are no bubbles, and pix_ready=0.
- FLUSH: dct_enable stays 1 for FLUSH_CYCLES more cycles, with dct_data holding the last pixel. dct_enable is therefore high for 64+FLUSH_CYCLES contiguous cycles, then drops to 0.
- WAIT_OUT: dct_enable=0. dct_output_enable is sampled only in this state; any high value earlier is ignored. A wait counter starts at 0 on entry and increments each cycle.
  - First cycle with dct_output_enable=1 → DONE.
  - Counter reaching TIMEOUT_CYCLES with output_enable still low → ERR.
  - If output_enable rises in the same cycle the counter hits the limit, output_enable wins.
- DONE (1 cycle): coef_valid=1, block_done=1, block_count += 1 (wraps 2^CNT_W-1 → 0), wr_ptr=0, then → FILL.
- ERR (1 cycle): timeout_err set (sticky), dct_clear=1, no coef_valid/block_done, block_count unchanged, wr_ptr=0, then → FILL.
- Pixels presented while pix_ready=0 are not consumed; upstream holds them.
- Throughput: at most one block per 64+CLEAR+64+FLUSH+latency_dct+1 cycles. There is no overlap of fill and feed.
- All outputs are registered; there are no combinational input→output paths except pix_ready, which is decoded from state only.

Decomposition:
- Shared package dct_ctrl_pkg:
  - state enum {FILL, CLEAR, FEED, FLUSH, WAIT_OUT, DONE, ERR}
  - BLOCK_PIXELS, PTR_W = $clog2(BLOCK_PIXELS)
  - default CLEAR/FLUSH/TIMEOUT constants.
- One sub-module, dct_pix_buf: 64 x DATA_W single-write/single-read buffer with synchronous registered read (1-cycle latency) and no reset on storage.
- The FSM, pointers and counters stay in dct_block_sequencer.

Test Plan:
- 64 pixels of 128 with pix_valid continuously high:
  - pix_ready drops the cycle after the 64th accept.
  - dct_clear high exactly 2 cycles.
  - dct_enable high exactly 66 contiguous cycles, every dct_data=128.
  - coef_valid/block_done pulse once; DCT Z[0][0]=0, all other coefficients 0; block_count=1.
- Checkerboard pattern ((i[0]^i[3])?255:0) with pix_valid deasserted every 3rd cycle: dct_data sequence during enable matches the written order exactly, with no bubbles in dct_enable.
- dct_output_enable tied low:
  - ERR reached 1000 cycles after WAIT_OUT entry; timeout_err=1 and stays 1.
  - block_done never pulses, block_count unchanged.
  - Next block still feeds normally.
- Three back-to-back random blocks:
  - block_count=3.
  - Each block is preceded by a 2-cycle dct_clear.
  - pix_ready=0 from CLEAR through DONE of each block.
- rst asserted mid-FEED (cycle 30 of enable):
  - All outputs are 0 immediately (asynchronously).
  - After release, state is FILL and pix_ready=1.
  - No dct_enable until 64 new pixels are accepted.
- dct_output_enable held high before WAIT_OUT (stale): ignored until WAIT_OUT, then DONE on the first WAIT_OUT cycle.
